// File: rtl/complex_fir_stream.sv
// complex_fir_stream: streaming complex FIR with loadable taps and valid/ready.
// Optional output saturation enabled by defining CFIR_SAT_EN (default: wrap).
module complex_fir_stream #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_r,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_r,
    input  logic signed [DATA_W-1:0] in_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_r,
    output logic signed [OUT_W-1:0]  out_i
);

    localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
    localparam int AW    = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state;
    logic [AW-1:0]           k;
    logic signed [DATA_W-1:0] x_r [TAPS];
    logic signed [DATA_W-1:0] x_i [TAPS];
    logic signed [COEF_W-1:0] h_r [TAPS];
    logic signed [COEF_W-1:0] h_i [TAPS];
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] prod_r;
    logic signed [ACC_W-1:0] prod_i;
    logic signed [ACC_W-1:0] acc_nr;
    logic signed [ACC_W-1:0] acc_ni;
    logic signed [OUT_W-1:0] y_r;
    logic signed [OUT_W-1:0] y_i;
    logic                    addr_ok;

    assign addr_ok = int'(coef_addr) < TAPS;

    // Complex product of the current tap, sign-extended to the accumulator width
    always_comb begin
        prod_r = ACC_W'(x_r[k]) * ACC_W'(h_r[k])
               - ACC_W'(x_i[k]) * ACC_W'(h_i[k]);
        prod_i = ACC_W'(x_r[k]) * ACC_W'(h_i[k])
               + ACC_W'(x_i[k]) * ACC_W'(h_r[k]);
        acc_nr = acc_r + prod_r;
        acc_ni = acc_i + prod_i;
    end

`ifdef CFIR_SAT_EN
    logic [ACC_W-OUT_W:0] hi_r;
    logic [ACC_W-OUT_W:0] hi_i;

    // Clamp each part to the signed output range when the upper bits disagree
    always_comb begin
        hi_r = acc_nr[ACC_W-1:OUT_W-1];
        hi_i = acc_ni[ACC_W-1:OUT_W-1];
        y_r  = acc_nr[OUT_W-1:0];
        y_i  = acc_ni[OUT_W-1:0];
        if (!(&hi_r || ~|hi_r)) begin
            y_r = acc_nr[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
        end
        if (!(&hi_i || ~|hi_i)) begin
            y_i = acc_ni[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    // Wrap: keep the low output bits of the final accumulator value
    always_comb begin
        y_r = acc_nr[OUT_W-1:0];
        y_i = acc_ni[OUT_W-1:0];
    end
`endif

    // Control FSM with delay line, coefficient store, accumulators and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            acc_r     <= '0;
            acc_i     <= '0;
            out_r     <= '0;
            out_i     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int j = 0; j < TAPS; j++) begin
                x_r[j] <= '0;
                x_i[j] <= '0;
                h_r[j] <= '0;
                h_i[j] <= '0;
            end
            h_r[0] <= COEF_W'(1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (coef_we && addr_ok) begin
                        h_r[coef_addr] <= coef_r;
                        h_i[coef_addr] <= coef_i;
                    end
                    if (in_valid) begin
                        for (int j = TAPS - 1; j > 0; j--) begin
                            x_r[j] <= x_r[j-1];
                            x_i[j] <= x_i[j-1];
                        end
                        x_r[0]   <= in_r;
                        x_i[0]   <= in_i;
                        acc_r    <= '0;
                        acc_i    <= '0;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc_r <= acc_nr;
                    acc_i <= acc_ni;
                    k     <= k + AW'(1);
                    if (k == LAST) begin
                        out_r     <= y_r;
                        out_i     <= y_i;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_fir_stream.sv
// tb_complex_fir_stream: directed vectors for complex_fir_stream.
// TAPS=4, OUT_W=16 so the saturation vector exercises narrowing.
module tb_complex_fir_stream;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     coef_we;
    logic [1:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_r;
    logic signed [COEF_W-1:0] coef_i;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_r;
    logic signed [DATA_W-1:0] in_i;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_r;
    logic signed [OUT_W-1:0]  out_i;

    int n_cmp = 0;
    int n_bad = 0;

    complex_fir_stream #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_r   (coef_r),
        .coef_i   (coef_i),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_r     (in_r),
        .in_i     (in_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_i    (out_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr_coef(input int a, input int r, input int i);
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_r    = 16'(r);
        coef_i    = 16'(i);
        step();
        coef_we   = 1'b0;
    endtask

    task automatic accept(input int r, input int i);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_idle", in_ready, 1);
        in_r     = 16'(r);
        in_i     = 16'(i);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic collect(output int lat, output longint gr, output longint gi);
        int  n;
        logic rdy_seen;
        n        = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            n++;
        end
        if (in_ready) rdy_seen = 1'b1;
        check("in_ready_busy", rdy_seen, 0);
        lat = n;
        gr  = out_r;
        gi  = out_i;
        if (out_ready) step();
    endtask

    task automatic send(input string tag, input int r, input int i,
                        input longint er, input longint ei);
        int     lat;
        longint gr;
        longint gi;
        accept(r, i);
        collect(lat, gr, gi);
        check({tag, "_lat"}, lat, TAPS);
        check({tag, "_r"}, gr, er);
        check({tag, "_i"}, gi, ei);
    endtask

    initial begin
        int     lat;
        longint gr;
        longint gi;
        int     conv_in  [5] = '{1, 2, 3, 4, 5};
        int     conv_exp [5] = '{1, 3, 6, 10, 14};

        rst       = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_r    = '0;
        coef_i    = '0;
        in_valid  = 1'b0;
        in_r      = '0;
        in_i      = '0;
        out_ready = 1'b1;
        do_reset();

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_r", out_r, 0);
        check("rst_out_i", out_i, 0);

        send("ident", 3, 4, 3, 4);

        wr_coef(0, 1, 2);
        send("cprod", 3, 4, -5, 10);

        do_reset();
        for (int t = 0; t < 4; t++) wr_coef(t, 1, 0);
        for (int s = 0; s < 5; s++) begin
            send($sformatf("conv%0d", s), conv_in[s], 0, conv_exp[s], 0);
        end

        out_ready = 1'b0;
        accept(6, 0);
        wr_coef(0, 100, 0);
        collect(lat, gr, gi);
        check("bp_r", gr, 18);
        wr_coef(1, 50, 0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid%0d", c), out_valid, 1);
            check($sformatf("bp_hold%0d", c), out_r, 18);
            check($sformatf("bp_rdy%0d", c), in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        send("gate", 7, 0, 22, 0);

        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_r    = 16'sd2;
        coef_i    = 16'sd0;
        accept(8, 0);
        coef_we   = 1'b0;
        collect(lat, gr, gi);
        check("wr_acc_r", gr, 34);

        do_reset();
        wr_coef(0, 32767, 0);
`ifdef CFIR_SAT_EN
        send("sat", 32767, 0, 32767, 0);
`else
        send("wrap", 32767, 0, 1, 0);
`endif

        accept(9, 9);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        send("post_rst", 7, 0, 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
